// File: rtl/pm_irq_pkg.sv
// Shared types for the 256Hz-timer interrupt controller: FSM states and
// register offsets relative to the controller base address.
package pm_irq_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_GAP  = 2'd2
  } irq_state_t;

  localparam logic [1:0] REG_ENABLE = 2'd0;
  localparam logic [1:0] REG_FLAGS  = 2'd1;
  localparam logic [1:0] REG_PRIO   = 2'd2;

endpackage

// File: rtl/timer256_irq_ctrl_if.sv
// Bus and CPU interrupt handshake signals of the timer256 interrupt controller.
interface timer256_irq_ctrl_if;
  logic        bus_write;
  logic        bus_read;
  logic [23:0] bus_address_in;
  logic [7:0]  bus_data_in;
  logic [7:0]  bus_data_out;
  logic        irq_req;
  logic [7:0]  irq_vector;
  logic [1:0]  irq_level;
  logic        irq_ack;

  // CPU / bus master side
  modport master (
    output bus_write, bus_read, bus_address_in, bus_data_in, irq_ack,
    input  bus_data_out, irq_req, irq_vector, irq_level
  );

  // Controller side
  modport slave (
    input  bus_write, bus_read, bus_address_in, bus_data_in, irq_ack,
    output bus_data_out, irq_req, irq_vector, irq_level
  );
endinterface

// File: rtl/irq_prio_sel.sv
// Fixed-priority selector: highest set candidate index wins (3 > 2 > 1 > 0).
module irq_prio_sel (
  input  logic [3:0] cand,
  output logic       found,
  output logic [1:0] idx
);

  // Priority encode the candidate mask
  always_comb begin
    found = 1'b1;
    idx   = 2'd0;
    casez (cand)
      4'b1???: idx = 2'd3;
      4'b01??: idx = 2'd2;
      4'b001?: idx = 2'd1;
      4'b0001: idx = 2'd0;
      default: found = 1'b0;
    endcase
  end

endmodule

// File: rtl/timer256_irq_ctrl.sv
// Interrupt controller for the four timer256 sources. Latches source pulses
// into pending flags, masks them with per-source enables and a group level,
// and presents one vectored request to the CPU with a req/ack handshake.
module timer256_irq_ctrl
  import pm_irq_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR   = 24'h2020,
  parameter logic [7:0]  VECTOR_BASE = 8'h20
) (
  input  logic                      clk,
  input  logic                      reset,
  timer256_irq_ctrl_if.slave        bus,
  input  logic [3:0]                src_irq,
  input  logic [1:0]                cpu_level
);

  logic [3:0] enable_q;
  logic [3:0] flags_q;
  logic [1:0] prio_q;
  logic [1:0] idx_q;
  logic [7:0] vector_q;
  logic [1:0] level_q;
  irq_state_t state_q;

  logic       sel_enable, sel_flags, sel_prio;
  logic       wr_enable, wr_flags, wr_prio;
  logic [3:0] cand;
  logic [3:0] clr;
  logic       found;
  logic [1:0] sel_idx;
  logic       eligible;
  logic       ack_fire;
  logic       src_live;
  logic       unused_read;

  // Reads are side-effect free, so the read strobe does not gate anything
  assign unused_read = bus.bus_read;

  assign sel_enable = (bus.bus_address_in == BASE_ADDR + 24'(REG_ENABLE));
  assign sel_flags  = (bus.bus_address_in == BASE_ADDR + 24'(REG_FLAGS));
  assign sel_prio   = (bus.bus_address_in == BASE_ADDR + 24'(REG_PRIO));
  assign wr_enable  = bus.bus_write & sel_enable;
  assign wr_flags   = bus.bus_write & sel_flags;
  assign wr_prio    = bus.bus_write & sel_prio;

  assign cand     = flags_q & enable_q;
  assign eligible = found && (prio_q != 2'd0) && (prio_q > cpu_level);
  assign ack_fire = (state_q == IRQ_REQ) && bus.irq_ack;
  assign src_live = flags_q[idx_q] & enable_q[idx_q];

  irq_prio_sel u_sel (
    .cand  (cand),
    .found (found),
    .idx   (sel_idx)
  );

  // Flag clear mask: software W1C plus the source being acknowledged
  always_comb begin
    clr = '0;
    if (wr_flags) clr = bus.bus_data_in[3:0];
    if (ack_fire) clr[idx_q] = 1'b1;
  end

  // Combinational register read-back; unmapped addresses read zero
  always_comb begin
    bus.bus_data_out = '0;
    if (sel_enable)     bus.bus_data_out = {4'b0, enable_q};
    else if (sel_flags) bus.bus_data_out = {4'b0, flags_q};
    else if (sel_prio)  bus.bus_data_out = {6'b0, prio_q};
  end

  // Bus-mapped registers and pending flags; a new pulse beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q <= '0;
      flags_q  <= '0;
      prio_q   <= '0;
    end else begin
      flags_q <= (flags_q & ~clr) | src_irq;
      if (wr_enable) enable_q <= bus.bus_data_in[3:0];
      if (wr_prio)   prio_q   <= bus.bus_data_in[1:0];
    end
  end

  // Request FSM: latch winner in IDLE, hold until ack or withdraw, one-cycle GAP after ack
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IRQ_IDLE;
      idx_q    <= '0;
      vector_q <= '0;
      level_q  <= '0;
    end else begin
      case (state_q)
        IRQ_IDLE: begin
          if (eligible) begin
            idx_q    <= sel_idx;
            vector_q <= VECTOR_BASE + 8'(sel_idx);
            level_q  <= prio_q;
            state_q  <= IRQ_REQ;
          end
        end
        IRQ_REQ: begin
          if (bus.irq_ack)                        state_q <= IRQ_GAP;
          else if (!src_live || prio_q == 2'd0)   state_q <= IRQ_IDLE;
        end
        IRQ_GAP:  state_q <= IRQ_IDLE;
        default:  state_q <= IRQ_IDLE;
      endcase
    end
  end

  assign bus.irq_req    = (state_q == IRQ_REQ);
  assign bus.irq_vector = vector_q;
  assign bus.irq_level  = level_q;

endmodule
